// File: rtl/diagv2_test_sequencer_pkg.sv
// Shared types and constants for the diagv2 batch test sequencer.
package diagv2_test_sequencer_pkg;

   // a7 value that marks a normal program exit
   localparam int unsigned SYS_EXIT = 93;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/diagv2_test_sequencer_if.sv
// Loader and core-control signals between the sequencer (master) and the
// loader / diagv2 core side (slave).
interface diagv2_test_sequencer_if #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 6
);
   logic             load_req;
   logic             load_done;
   logic [CNT_W-1:0] test_idx;
   logic             core_reset;
   logic             core_halt;
   logic             core_ecall;
   logic [XLEN-1:0]  syscall_id;
   logic [XLEN-1:0]  exit_arg;

   modport master (
      output load_req, test_idx, core_reset, core_halt,
      input  load_done, core_ecall, syscall_id, exit_arg
   );

   modport slave (
      input  load_req, test_idx, core_reset, core_halt,
      output load_done, core_ecall, syscall_id, exit_arg
   );
endinterface

// File: rtl/diagv2_test_sequencer_watchdog.sv
// Clear/enable cycle counter with a terminal-count flag. The sequencer reuses
// one instance for both the reset-hold interval and the run watchdog.
module diagv2_test_sequencer_watchdog #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic         expired
);
   logic [W-1:0] count;

   // Count enabled cycles; clear has priority so the next interval starts at 0.
   // NOTE: async active-low reset lives in the sensitivity list; all state
   // uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == terminal);
endmodule

// File: rtl/diagv2_test_sequencer.sv
// Batch run controller for the diagv2 core: load, hold in reset, run until
// ECALL or watchdog, score the result, advance to the next test.
module diagv2_test_sequencer
   import diagv2_test_sequencer_pkg::*;
#(
   parameter int  NUM_TESTS      = 50,
   parameter int  XLEN           = 64,
   parameter int  RESET_CYCLES   = 2,
   parameter int  TIMEOUT_CYCLES = 100000,
   localparam int CNT_W          = $clog2(NUM_TESTS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   diagv2_test_sequencer_if.master bus,
   output logic                    busy,
   output logic                    done,
   output logic                    result_valid,
   output logic [XLEN-1:0]         last_status,
   output logic [CNT_W-1:0]        pass_count,
   output logic [CNT_W-1:0]        fail_count,
   output logic                    err_bad_ecall,
   output logic                    err_timeout
);
   localparam int           WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] HOLD_TC = WD_W'(RESET_CYCLES - 1);
   localparam logic [WD_W-1:0] RUN_TC  = WD_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] test_idx;
   logic             wd_clear, wd_enable, wd_expired;
   logic             last_test;
   logic             load_req_c, core_reset_c, core_halt_c;

   assign last_test = (test_idx == CNT_W'(NUM_TESTS - 1));

   // Watchdog restarts at 0 on every state change; counts only in HOLD/RUN.
   assign wd_clear  = (state_d != state_q);
   assign wd_enable = (state_q == ST_HOLD) || (state_q == ST_RUN);

   diagv2_test_sequencer_watchdog #(.W(WD_W)) u_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear    (wd_clear),
      .enable   (wd_enable),
      .terminal ((state_q == ST_HOLD) ? HOLD_TC : RUN_TC),
      .expired  (wd_expired)
   );

   // State register; reset lands in IDLE so core_reset asserts asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; abort overrides everything outside IDLE.
   // NOTE: state_d gets a default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (start)                   state_d = ST_LOAD;
            ST_LOAD:          if (bus.load_done)           state_d = ST_HOLD;
            ST_HOLD:          if (wd_expired)              state_d = ST_RUN;
            ST_RUN:           if (bus.core_ecall || wd_expired) state_d = ST_CHECK;
            ST_CHECK:         state_d = last_test ? ST_DONE : ST_LOAD;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      load_req_c   = (state_q == ST_LOAD);
      core_reset_c = !((state_q == ST_RUN) || (state_q == ST_CHECK));
      core_halt_c  = (state_q == ST_CHECK);
      busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE));
      done         = (state_q == ST_DONE);
      result_valid = (state_q == ST_CHECK);
   end

   assign bus.load_req   = load_req_c;
   assign bus.core_reset = core_reset_c;
   assign bus.core_halt  = core_halt_c;
   assign bus.test_idx   = test_idx;

   // Scoring datapath: status capture on RUN exit, counters on CHECK exit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         test_idx      <= '0;
         pass_count    <= '0;
         fail_count    <= '0;
         last_status   <= '0;
         err_bad_ecall <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE || state_q == ST_DONE) && state_d == ST_LOAD) begin
            test_idx      <= '0;
            pass_count    <= '0;
            fail_count    <= '0;
            err_bad_ecall <= 1'b0;
            err_timeout   <= 1'b0;
         end
         if (state_q == ST_RUN && state_d == ST_CHECK) begin
            // ECALL wins over a watchdog expiry in the same cycle
            if (bus.core_ecall) begin
               if (bus.syscall_id == XLEN'(SYS_EXIT)) begin
                  last_status <= bus.exit_arg;
               end else begin
                  last_status   <= '1;
                  err_bad_ecall <= 1'b1;
               end
            end else begin
               last_status <= '1;
               err_timeout <= 1'b1;
            end
         end
         if (state_q == ST_CHECK && state_d != ST_IDLE) begin
            if (last_status == '0) pass_count <= pass_count + 1'b1;
            else                   fail_count <= fail_count + 1'b1;
            if (state_d == ST_LOAD) test_idx <= test_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Randomized scoreboard bench for diagv2_test_sequencer.
module tb_diagv2_test_sequencer;
   localparam int NT = 6;
   localparam int XL = 64;
   localparam int RC = 2;
   localparam int TO = 20;
   localparam int CW = $clog2(NT + 1);

   localparam int K_EXIT0 = 0, K_EXITN = 1, K_BAD = 2, K_TIMEOUT = 3,
                  K_LAST = 4, K_ABORT = 5, K_RESET = 6;

   logic          clk = 1'b0;
   logic          reset, start, abort;
   logic          busy, done, result_valid, err_bad_ecall, err_timeout;
   logic [XL-1:0] last_status;
   logic [CW-1:0] pass_count, fail_count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [XL-1:0] exp_q[$];
   int            exp_pass, exp_fail;
   bit            exp_bad, exp_to;

   diagv2_test_sequencer_if #(.XLEN(XL), .CNT_W(CW)) bus_if ();

   diagv2_test_sequencer #(
      .NUM_TESTS(NT), .XLEN(XL), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .bus(bus_if),
      .busy(busy), .done(done), .result_valid(result_valid),
      .last_status(last_status), .pass_count(pass_count), .fail_count(fail_count),
      .err_bad_ecall(err_bad_ecall), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every result_valid pulse must match the oldest expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (result_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL result_valid: got pulse expected none (status %0h)", last_status);
            end else begin
               check("last_status", last_status, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Reference: status is 0 for a clean exit, a0 for a nonzero exit,
   // all-ones for a bad ECALL or a hang.
   task automatic expect_result(input int kind, input logic [XL-1:0] a0);
      logic [XL-1:0] s;
      case (kind)
         K_EXIT0, K_LAST: s = '0;
         K_EXITN:         s = a0;
         default:         s = '1;
      endcase
      exp_q.push_back(s);
      if (s == '0) exp_pass++;
      else         exp_fail++;
      if (kind == K_BAD)     exp_bad = 1'b1;
      if (kind == K_TIMEOUT) exp_to  = 1'b1;
   endtask

   task automatic do_ecall(input int delay, input logic [XL-1:0] a7, input logic [XL-1:0] a0);
      repeat (delay) step();
      bus_if.core_ecall = 1'b1;
      bus_if.syscall_id = a7;
      bus_if.exit_arg   = a0;
      step();
      bus_if.core_ecall = 1'b0;
      check("core_halt after ecall", bus_if.core_halt, 1'b1);
   endtask

   task automatic start_batch();
      start = 1'b1;
      step();
      start = 1'b0;
      exp_pass = 0; exp_fail = 0; exp_bad = 1'b0; exp_to = 1'b0;
      check("busy after start", busy, 1'b1);
   endtask

   task automatic run_test(input int idx, input int kind, input logic [XL-1:0] a7,
                           input logic [XL-1:0] a0);
      int n;
      n = 0;
      while (!bus_if.load_req && n < 50) begin step(); n++; end
      check("load_req asserted", bus_if.load_req, 1'b1);
      check("test_idx", bus_if.test_idx, idx);
      repeat ($urandom_range(0, 3)) step();
      bus_if.load_done = 1'b1;
      step();
      bus_if.load_done = 1'b0;
      check("load_req drop", bus_if.load_req, 1'b0);
      n = 0;
      while (bus_if.core_reset && n < 10) begin step(); n++; end
      check("hold cycles", n, RC);
      case (kind)
         K_EXIT0: begin expect_result(kind, a0); do_ecall($urandom_range(0, 8), 93, 0); end
         K_EXITN: begin expect_result(kind, a0); do_ecall($urandom_range(0, 8), 93, a0); end
         K_BAD:   begin expect_result(kind, a0); do_ecall($urandom_range(0, 8), a7, a0); end
         K_LAST:  begin expect_result(kind, a0); do_ecall(TO - 1, 93, 0); end
         K_TIMEOUT: begin
            expect_result(kind, a0);
            n = 0;
            while (!bus_if.core_halt && n < TO + 5) begin step(); n++; end
            check("timeout run cycles", n, TO);
         end
         K_ABORT: begin
            repeat (3) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
            check("abort busy", busy, 1'b0);
            check("abort core_reset", bus_if.core_reset, 1'b1);
            check("abort load_req", bus_if.load_req, 1'b0);
            repeat (2) step();
            check("idle after abort load_req", bus_if.load_req, 1'b0);
         end
         default: begin
            #2;
            reset = 1'b0;
            #1;
            check("async reset core_reset", bus_if.core_reset, 1'b1);
            check("async reset pass_count", pass_count, 0);
            check("async reset test_idx", bus_if.test_idx, 0);
            check("async reset busy", busy, 1'b0);
            @(posedge clk);
            #1;
            reset = 1'b1;
         end
      endcase
   endtask

   task automatic finish_batch();
      int n;
      n = 0;
      while (!done && n < 100) begin step(); n++; end
      check("done", done, 1'b1);
      check("busy at done", busy, 1'b0);
      check("core_reset at done", bus_if.core_reset, 1'b1);
      check("pass_count", pass_count, exp_pass);
      check("fail_count", fail_count, exp_fail);
      check("err_bad_ecall", err_bad_ecall, exp_bad);
      check("err_timeout", err_timeout, exp_to);
   endtask

   initial begin
      int kinds1[NT] = '{K_EXIT0, K_EXITN, K_BAD, K_TIMEOUT, K_LAST, K_EXIT0};
      logic [XL-1:0] ra7, ra0;

      reset = 1'b0; start = 1'b0; abort = 1'b0;
      bus_if.load_done = 1'b0; bus_if.core_ecall = 1'b0;
      bus_if.syscall_id = '0; bus_if.exit_arg = '0;
      #3;
      check("reset core_reset", bus_if.core_reset, 1'b1);
      check("reset core_halt", bus_if.core_halt, 1'b0);
      check("reset load_req", bus_if.load_req, 1'b0);
      check("reset test_idx", bus_if.test_idx, 0);
      check("reset counts", {pass_count, fail_count}, 0);
      check("reset last_status", last_status, 0);
      check("reset flags", {busy, done, result_valid, err_bad_ecall, err_timeout}, 0);
      step();
      reset = 1'b1;
      step();

      // Batch 1: directed mix covering exit codes, bad ECALL, hang, late ECALL
      start_batch();
      for (int i = 0; i < NT; i++) run_test(i, kinds1[i], 64, 5);
      finish_batch();

      // Batch 2: restart from DONE with randomized outcomes
      start_batch();
      for (int i = 0; i < NT; i++) begin
         ra7 = XL'($urandom_range(0, 200));
         if (ra7 == 93) ra7 = 64;
         ra0 = {$urandom, $urandom} | 64'd1;
         run_test(i, $urandom_range(0, 4), ra7, ra0);
      end
      finish_batch();

      // Batch 3: one pass, then abort during RUN; counts retained
      start_batch();
      run_test(0, K_EXIT0, 0, 0);
      run_test(1, K_ABORT, 0, 0);
      check("abort keeps pass_count", pass_count, exp_pass);

      // Abort during LOAD
      start_batch();
      check("load_req in load", bus_if.load_req, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort in load load_req", bus_if.load_req, 1'b0);
      check("abort in load busy", busy, 1'b0);

      // Batch 4: one pass, then async reset during RUN
      start_batch();
      run_test(0, K_EXIT0, 0, 0);
      run_test(1, K_RESET, 0, 0);
      repeat (3) step();

      check("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
